// File: rtl/dram_arb_pkg.sv
// Shared types and default sizing for the DRAM Wishbone arbiter.
`timescale 1ns/1ps
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_MASTERS    = 4;
    localparam int DEF_WORD_SIZE      = 128;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/dram_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward and wrapping modulo N.
`timescale 1ns/1ps
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand_s [N];

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand_s[k] = IW'((int'(ptr) + k) % N);
    end

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            valid = valid | req[cand_s[k]];
            idx   = req[cand_s[k]] ? cand_s[k] : idx;
        end
    end

endmodule

// File: rtl/dram_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the DRAM controller slave port.
// Optional watchdog abort is enabled with the ARB_TIMEOUT_EN macro.
`timescale 1ns/1ps
module dram_wb_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              user_clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i,
    output logic [WORD_SIZE-1:0]              m_data_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [WORD_SIZE-1:0]              s_data_o,
    input  logic [WORD_SIZE-1:0]              s_data_i,
    input  logic                              s_ack_i,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_o,
    output logic                              busy_o
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dram_wb_arbiter: NUM_MASTERS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [NUM_MASTERS-1:0] req_s;
    logic [ADDR_WIDTH-1:0]  addr_s [NUM_MASTERS];
    logic [WORD_SIZE-1:0]   wdata_s [NUM_MASTERS];
    logic                   pick_valid_s;
    logic [IW-1:0]          pick_idx_s;

    arb_state_t             state_r, state_nxt_s;
    logic [IW-1:0]          rr_ptr_r, rr_ptr_nxt_s;
    logic [IW-1:0]          grant_r, grant_nxt_s;
    logic                   s_cyc_r, s_cyc_nxt_s;
    logic                   s_we_r, s_we_nxt_s;
    logic [ADDR_WIDTH-1:0]  s_addr_r, s_addr_nxt_s;
    logic [WORD_SIZE-1:0]   s_data_r, s_data_nxt_s;
    logic [WORD_SIZE-1:0]   m_data_r, m_data_nxt_s;
    logic [NUM_MASTERS-1:0] m_ack_r, m_ack_nxt_s;
    logic                   busy_r;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]          wdog_r, wdog_nxt_s;
    logic [NUM_MASTERS-1:0] m_err_r, m_err_nxt_s;
`endif

    assign req_s = m_cyc_i & m_stb_i;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_s[i]  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_s[i] = m_data_i[i*WORD_SIZE +: WORD_SIZE];
    end

    rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
        .req   (req_s),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next-state and next-output decode for the arbitration FSM.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        grant_nxt_s  = grant_r;
        s_cyc_nxt_s  = s_cyc_r;
        s_we_nxt_s   = s_we_r;
        s_addr_nxt_s = s_addr_r;
        s_data_nxt_s = s_data_r;
        m_data_nxt_s = m_data_r;
        m_ack_nxt_s  = '0;
`ifdef ARB_TIMEOUT_EN
        wdog_nxt_s   = wdog_r;
        m_err_nxt_s  = '0;
`endif
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_nxt_s  = pick_idx_s;
                    s_we_nxt_s   = m_we_i[pick_idx_s];
                    s_addr_nxt_s = addr_s[pick_idx_s];
                    s_data_nxt_s = wdata_s[pick_idx_s];
                    s_cyc_nxt_s  = 1'b1;
                    state_nxt_s  = BUSY;
`ifdef ARB_TIMEOUT_EN
                    wdog_nxt_s   = '0;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                // A completing ack takes priority over a simultaneous timeout.
                if (s_ack_i) begin
                    m_data_nxt_s = s_data_i;
                    m_ack_nxt_s  = ONE_HOT0 << grant_r;
                    s_cyc_nxt_s  = 1'b0;
                    rr_ptr_nxt_s = (grant_r == IW'(NUM_MASTERS - 1)) ? '0 : grant_r + IW'(1);
                    state_nxt_s  = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wdog_r == CW'(TIMEOUT_CYCLES - 1)) begin
                    m_err_nxt_s  = ONE_HOT0 << grant_r;
                    s_cyc_nxt_s  = 1'b0;
                    rr_ptr_nxt_s = (grant_r == IW'(NUM_MASTERS - 1)) ? '0 : grant_r + IW'(1);
                    state_nxt_s  = DONE;
                end else begin
                    wdog_nxt_s = wdog_r + CW'(1);
                end
`else
                else begin
                    state_nxt_s = BUSY;
                end
`endif
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                s_cyc_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge user_clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge user_clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= '0;
            grant_r  <= '0;
            s_cyc_r  <= 1'b0;
            s_we_r   <= 1'b0;
            s_addr_r <= '0;
            s_data_r <= '0;
            m_data_r <= '0;
            m_ack_r  <= '0;
            busy_r   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdog_r   <= '0;
            m_err_r  <= '0;
`endif
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
            grant_r  <= grant_nxt_s;
            s_cyc_r  <= s_cyc_nxt_s;
            s_we_r   <= s_we_nxt_s;
            s_addr_r <= s_addr_nxt_s;
            s_data_r <= s_data_nxt_s;
            m_data_r <= m_data_nxt_s;
            m_ack_r  <= m_ack_nxt_s;
            busy_r   <= (state_nxt_s != IDLE);
`ifdef ARB_TIMEOUT_EN
            wdog_r   <= wdog_nxt_s;
            m_err_r  <= m_err_nxt_s;
`endif
        end
    end

    assign s_cyc_o  = s_cyc_r;
    assign s_stb_o  = s_cyc_r;
    assign s_we_o   = s_we_r;
    assign s_addr_o = s_addr_r;
    assign s_data_o = s_data_r;
    assign m_data_o = m_data_r;
    assign m_ack_o  = m_ack_r;
    assign grant_o  = grant_r;
    assign busy_o   = busy_r;
`ifdef ARB_TIMEOUT_EN
    assign m_err_o  = m_err_r;
`else
    assign m_err_o  = '0;
`endif

endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Directed self-checking bench for dram_wb_arbiter (4 masters, 128-bit data).
`timescale 1ns/1ps
module tb_dram_wb_arbiter;
    localparam int NM = 4;
    localparam int WS = 128;
    localparam int AW = 32;
    localparam int TO = 16;

    logic              user_clk_i = 1'b0;
    logic              rst_i;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM*WS-1:0]  m_data_i;
    logic [WS-1:0]     m_data_o;
    logic [NM-1:0]     m_ack_o, m_err_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_addr_o;
    logic [WS-1:0]     s_data_o, s_data_i;
    logic              s_ack_i;
    logic [1:0]        grant_o;
    logic              busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    dram_wb_arbiter #(
        .NUM_MASTERS(NM), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .user_clk_i(user_clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i),
        .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 user_clk_i = ~user_clk_i;

    task automatic tick();
        @(posedge user_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [WS-1:0] d);
        m_cyc_i[i] = req;
        m_stb_i[i] = req;
        m_we_i[i]  = we;
        m_addr_i[i*AW +: AW] = a;
        m_data_i[i*WS +: WS] = d;
    endtask

    localparam logic [WS-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [WS-1:0] RD_VAL = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [WS-1:0] CAFE   = {4{32'hCAFEF00D}};

    initial begin
        int exp_g[5];
        exp_g = '{3, 0, 1, 2, 3};
        rst_i = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0;
        s_ack_i = 1'b0; s_data_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("reset_stb", WS'(s_stb_o), WS'(1'b0));
        check("reset_cyc", WS'(s_cyc_o), WS'(1'b0));
        check("reset_ack", WS'(m_ack_o), WS'(4'b0000));
        check("reset_err", WS'(m_err_o), WS'(4'b0000));
        check("reset_grant", WS'(grant_o), WS'(2'd0));
        check("reset_busy", WS'(busy_o), WS'(1'b0));

        // Single write from master 0, ack in the third BUSY cycle
        set_m(0, 1'b1, 1'b1, 32'h0, PAT_A5);
        s_data_i = CAFE;
        tick();
        check("wr_stb", WS'(s_stb_o), WS'(1'b1));
        check("wr_cyc", WS'(s_cyc_o), WS'(1'b1));
        check("wr_we", WS'(s_we_o), WS'(1'b1));
        check("wr_addr", WS'(s_addr_o), WS'(32'h0));
        check("wr_data", s_data_o, PAT_A5);
        check("wr_grant", WS'(grant_o), WS'(2'd0));
        check("wr_busy", WS'(busy_o), WS'(1'b1));
        tick();
        check("wr_stb_hold", WS'(s_stb_o), WS'(1'b1));
        check("wr_no_early_ack", WS'(m_ack_o), WS'(4'b0000));
        tick();
        s_ack_i = 1'b1;
        tick();
        check("wr_ack", WS'(m_ack_o), WS'(4'b0001));
        check("wr_stb_drop", WS'(s_stb_o), WS'(1'b0));
        check("wr_mdata", m_data_o, CAFE);
        check("wr_done_busy", WS'(busy_o), WS'(1'b1));
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, '0);
        tick();
        check("wr_ack_clear", WS'(m_ack_o), WS'(4'b0000));
        check("wr_idle", WS'(busy_o), WS'(1'b0));

        // Read from master 2
        set_m(2, 1'b1, 1'b0, 32'h40, '0);
        tick();
        check("rd_grant", WS'(grant_o), WS'(2'd2));
        check("rd_addr", WS'(s_addr_o), WS'(32'h40));
        check("rd_we", WS'(s_we_o), WS'(1'b0));
        s_ack_i = 1'b1;
        s_data_i = RD_VAL;
        tick();
        check("rd_ack", WS'(m_ack_o), WS'(4'b0100));
        check("rd_data", m_data_o, RD_VAL);
        s_ack_i = 1'b0;
        s_data_i = '0;
        set_m(2, 1'b0, 1'b0, 32'h0, '0);
        tick();
        check("rd_data_hold", m_data_o, RD_VAL);

        // Fairness: all masters request, rr pointer starts at 3
        for (int i = 0; i < NM; i++) begin
            set_m(i, 1'b1, 1'b0, AW'(32'h1000 * (i + 1)), '0);
        end
        for (int n = 0; n < 5; n++) begin
            tick();
            check("fair_grant", WS'(grant_o), WS'(exp_g[n]));
            check("fair_addr", WS'(s_addr_o), WS'(32'h1000 * (exp_g[n] + 1)));
            s_ack_i = 1'b1;
            tick();
            check("fair_ack", WS'(m_ack_o), WS'(4'b0001 << exp_g[n]));
            s_ack_i = 1'b0;
            tick();
            check("fair_idle", WS'(busy_o), WS'(1'b0));
        end
        for (int i = 0; i < NM; i++) begin
            set_m(i, 1'b0, 1'b0, 32'h0, '0);
        end

        // Abandon: master 1 drops its cycle mid-transaction
        set_m(1, 1'b1, 1'b1, 32'h2000, PAT_A5);
        set_m(2, 1'b1, 1'b0, 32'h3000, '0);
        tick();
        check("ab_grant", WS'(grant_o), WS'(2'd1));
        set_m(1, 1'b0, 1'b0, 32'h0, '0);
        tick();
        check("ab_stb_hold", WS'(s_stb_o), WS'(1'b1));
        check("ab_addr_hold", WS'(s_addr_o), WS'(32'h2000));
        tick();
        check("ab_stb_hold2", WS'(s_stb_o), WS'(1'b1));
        s_ack_i = 1'b1;
        tick();
        check("ab_ack", WS'(m_ack_o), WS'(4'b0010));
        s_ack_i = 1'b0;
        tick();
        tick();
        check("ab_next_grant", WS'(grant_o), WS'(2'd2));
        check("ab_next_addr", WS'(s_addr_o), WS'(32'h3000));
        s_ack_i = 1'b1;
        tick();
        check("ab_next_ack", WS'(m_ack_o), WS'(4'b0100));
        s_ack_i = 1'b0;
        set_m(2, 1'b0, 1'b0, 32'h0, '0);
        tick();

        // Stray ack in IDLE
        s_ack_i = 1'b1;
        tick();
        check("idle_ack_ignored", WS'(m_ack_o), WS'(4'b0000));
        check("idle_stays", WS'(busy_o), WS'(1'b0));
        s_ack_i = 1'b0;

        // Stall: master 3 never acked
        set_m(3, 1'b1, 1'b0, 32'h4000, '0);
        tick();
        check("to_grant", WS'(grant_o), WS'(2'd3));
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            tick();
            check("to_no_err_yet", WS'(m_err_o), WS'(4'b0000));
        end
        tick();
        check("to_err", WS'(m_err_o), WS'(4'b1000));
        check("to_no_ack", WS'(m_ack_o), WS'(4'b0000));
        check("to_stb_drop", WS'(s_stb_o), WS'(1'b0));
        set_m(3, 1'b0, 1'b0, 32'h0, '0);
        tick();
        check("to_err_clear", WS'(m_err_o), WS'(4'b0000));
        s_ack_i = 1'b1;
        tick();
        check("to_late_ack", WS'(m_ack_o), WS'(4'b0000));
        s_ack_i = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check("stall_stb_hold", WS'(s_stb_o), WS'(1'b1));
        check("stall_no_err", WS'(m_err_o), WS'(4'b0000));
        s_ack_i = 1'b1;
        tick();
        check("stall_ack", WS'(m_ack_o), WS'(4'b1000));
        s_ack_i = 1'b0;
        set_m(3, 1'b0, 1'b0, 32'h0, '0);
        tick();
`endif

        // Move pointer to 2, then reset in the middle of a transaction
        s_data_i = {8{16'h5555}};
        set_m(1, 1'b1, 1'b0, 32'h5000, '0);
        tick();
        check("pre_rst_grant", WS'(grant_o), WS'(2'd1));
        s_ack_i = 1'b1;
        tick();
        check("pre_rst_data", m_data_o, {8{16'h5555}});
        s_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, '0);
        tick();
        set_m(2, 1'b1, 1'b1, 32'h6000, PAT_A5);
        tick();
        check("mid_grant", WS'(grant_o), WS'(2'd2));
        tick();
        rst_i = 1'b1;
        set_m(0, 1'b1, 1'b0, 32'h7000, '0);
        set_m(3, 1'b1, 1'b0, 32'h8000, '0);
        tick();
        check("rst_stb", WS'(s_stb_o), WS'(1'b0));
        check("rst_cyc", WS'(s_cyc_o), WS'(1'b0));
        check("rst_grant", WS'(grant_o), WS'(2'd0));
        check("rst_busy", WS'(busy_o), WS'(1'b0));
        check("rst_mdata", m_data_o, '0);
        check("rst_addr", WS'(s_addr_o), WS'(32'h0));
        check("rst_sdata", s_data_o, '0);
        rst_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, '0);
        set_m(2, 1'b0, 1'b0, 32'h0, '0);
        set_m(3, 1'b0, 1'b0, 32'h0, '0);
        s_ack_i = 1'b1;
        tick();
        check("rst_late_ack", WS'(m_ack_o), WS'(4'b0000));
        s_ack_i = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h7000, '0);
        set_m(2, 1'b1, 1'b1, 32'h6000, PAT_A5);
        set_m(3, 1'b1, 1'b0, 32'h8000, '0);
        tick();
        check("post_rst_grant", WS'(grant_o), WS'(2'd0));
        check("post_rst_addr", WS'(s_addr_o), WS'(32'h7000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
